// File: rtl/stack_arbiter_if.sv
// stack_arbiter_if: client handshakes, stack strobes and status for stack_arbiter.
// The optional Err_Cnt signal exists only when STACK_ARB_ERR_CNT_EN is defined.
interface stack_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 4
);
    logic              Req0, Op0, Gnt0, Ack0, Err0;
    logic [DATA_W-1:0] Din0, Dout0;
    logic              Req1, Op1, Gnt1, Ack1, Err1;
    logic [DATA_W-1:0] Din1, Dout1;
    logic              Stk_Push, Stk_Pop;
    logic [DATA_W-1:0] Stk_Din, Stk_Dout;
    logic [CNT_W-1:0]  Count;
    logic              Full, Empty;
`ifdef STACK_ARB_ERR_CNT_EN
    logic [7:0]        Err_Cnt;
`endif

    // Arbiter side
    modport slave (
        input  Req0, Op0, Din0, Req1, Op1, Din1, Stk_Dout,
        output Gnt0, Ack0, Err0, Dout0, Gnt1, Ack1, Err1, Dout1,
        output Stk_Push, Stk_Pop, Stk_Din, Count, Full, Empty
`ifdef STACK_ARB_ERR_CNT_EN
        , output Err_Cnt
`endif
    );

    // Client / stack side
    modport master (
        output Req0, Op0, Din0, Req1, Op1, Din1, Stk_Dout,
        input  Gnt0, Ack0, Err0, Dout0, Gnt1, Ack1, Err1, Dout1,
        input  Stk_Push, Stk_Pop, Stk_Din, Count, Full, Empty
`ifdef STACK_ARB_ERR_CNT_EN
        , input Err_Cnt
`endif
    );
endinterface

// File: rtl/stack_arbiter.sv
// stack_arbiter: two-client round-robin arbiter/sequencer in front of a shared
// LIFO stack. Tracks occupancy itself and rejects push-when-full and
// pop-when-empty with an error response. One transaction in flight at a time.
// Optional: define STACK_ARB_ERR_CNT_EN to add a saturating 8-bit error counter.
module stack_arbiter #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input logic           Clk,
    input logic           RstN,
    stack_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    state_t            state_q, state_d;
    logic              win_q, win_d;      // winning client id
    logic              op_q, op_d;        // 1 = push
    logic [DATA_W-1:0] data_q, data_d;    // latched push data, drives Stk_Din
    logic              err_q, err_d;      // rejected-operation flag
    logic              prio_q, prio_d;    // client that wins a tie
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic              full, empty;
    logic              in_issue, in_resp;

    assign full     = (count_q == CNT_MAX);
    assign empty    = (count_q == '0);
    assign in_issue = (state_q == ISSUE);
    assign in_resp  = (state_q == RESP);

    // State and datapath registers
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            op_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            prio_q  <= 1'b0;
            count_q <= '0;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
            prio_q  <= prio_d;
            count_q <= count_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    // Next-state: arbitration in IDLE, occupancy check in ISSUE, read capture in WAIT
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        prio_d  = prio_q;
        count_d = count_q;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    // Tie goes to prio_q; a lone requester always wins
                    win_d   = (bus.Req0 && bus.Req1) ? prio_q : bus.Req1;
                    op_d    = win_d ? bus.Op1 : bus.Op0;
                    data_d  = win_d ? bus.Din1 : bus.Din0;
                    err_d   = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (op_q) begin
                    if (!full) count_d = count_q + 1'b1;
                    else       err_d   = 1'b1;
                    state_d = RESP;
                end else if (!empty) begin
                    count_d = count_q - 1'b1;
                    state_d = WAIT;
                end else begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                // Stack read data is valid the cycle after the pop strobe
                if (win_q) dout1_d = bus.Stk_Dout;
                else       dout0_d = bus.Stk_Dout;
                state_d = RESP;
            end
            RESP: begin
                prio_d  = ~win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STACK_ARB_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    // Count error responses, saturating at 255
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN)                                  err_cnt_q <= '0;
        else if (in_resp && err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.Err_Cnt = err_cnt_q;
`endif

    // Outputs decode from registered state only; no input-to-output paths
    assign bus.Gnt0     = in_issue && !win_q;
    assign bus.Gnt1     = in_issue &&  win_q;
    assign bus.Ack0     = in_resp  && !win_q;
    assign bus.Ack1     = in_resp  &&  win_q;
    assign bus.Err0     = in_resp  && !win_q && err_q;
    assign bus.Err1     = in_resp  &&  win_q && err_q;
    assign bus.Dout0    = dout0_q;
    assign bus.Dout1    = dout1_q;
    assign bus.Stk_Push = in_issue &&  op_q && !full;
    assign bus.Stk_Pop  = in_issue && !op_q && !empty;
    assign bus.Stk_Din  = data_q;
    assign bus.Count    = count_q;
    assign bus.Full     = full;
    assign bus.Empty    = empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed tests for stack_arbiter with a behavioural 8-deep stack.
module tb_stack_arbiter;
    logic Clk  = 1'b0;
    logic RstN = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    stack_arbiter_if #(.DATA_W(4), .CNT_W(4)) bus ();

    stack_arbiter #(.DATA_W(4), .DEPTH(8), .CNT_W(4)) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    // Behavioural stack: registered read data one cycle after the pop strobe
    logic [3:0] mem [8];
    int         sp;
    logic [3:0] stk_dout_q;
    always @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            sp         <= 0;
            stk_dout_q <= '0;
        end else if (bus.Stk_Push) begin
            mem[sp[2:0]] <= bus.Stk_Din;
            sp           <= sp + 1;
        end else if (bus.Stk_Pop) begin
            stk_dout_q <= mem[(sp - 1) & 7];
            sp         <= sp - 1;
        end
    end
    assign bus.Stk_Dout = stk_dout_q;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        RstN = 1'b0;
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.Op0 = 1'b0;  bus.Op1 = 1'b0;
        bus.Din0 = '0;   bus.Din1 = '0;
        repeat (2) @(negedge Clk);
        RstN = 1'b1;
    endtask

    // One transaction; lat counts falling edges from request to Ack
    task automatic txn(input bit c, input bit op, input logic [3:0] d,
                       output int lat, output bit err, output bit saw_push,
                       output bit saw_pop, output logic [3:0] pdin);
        bit done = 0;
        lat = 0; err = 0; saw_push = 0; saw_pop = 0; pdin = '0;
        @(negedge Clk);
        if (c) begin bus.Req1 = 1'b1; bus.Op1 = op; bus.Din1 = d; end
        else   begin bus.Req0 = 1'b1; bus.Op0 = op; bus.Din0 = d; end
        for (int i = 1; i <= 8 && !done; i++) begin
            @(negedge Clk);
            if (bus.Stk_Push) begin saw_push = 1; pdin = bus.Stk_Din; end
            if (bus.Stk_Pop) saw_pop = 1;
            if (c ? bus.Ack1 : bus.Ack0) begin
                done = 1;
                lat  = i;
                err  = c ? bus.Err1 : bus.Err0;
            end
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        if (!done) chk("ack_timeout", 0, 1);
    endtask

    int         lat;
    bit         err, sp_seen, pop_seen;
    logic [3:0] pdin;
    int         order [4];
    int         nack, n0, n1, both_gnt;

    initial begin
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        bus.Op0 = 1'b0;  bus.Op1 = 1'b0;
        bus.Din0 = '0;   bus.Din1 = '0;

        // Reset state
        do_reset();
        #1;
        chk("rst_count", bus.Count, 0);
        chk("rst_empty", bus.Empty, 1);
        chk("rst_full",  bus.Full, 0);
        chk("rst_strobes", {bus.Gnt0, bus.Gnt1, bus.Ack0, bus.Ack1, bus.Err0, bus.Err1, bus.Stk_Push, bus.Stk_Pop}, 0);
        chk("rst_data", {bus.Dout0, bus.Dout1, bus.Stk_Din}, 0);
`ifdef STACK_ARB_ERR_CNT_EN
        chk("rst_errcnt", bus.Err_Cnt, 0);
`endif

        // Single push of A by client 0
        txn(0, 1, 4'hA, lat, err, sp_seen, pop_seen, pdin);
        chk("pushA_lat", lat, 2);
        chk("pushA_err", err, 0);
        chk("pushA_strobe", sp_seen, 1);
        chk("pushA_din", pdin, 4'hA);
        chk("pushA_count", bus.Count, 1);
        chk("pushA_empty", bus.Empty, 0);

        // Push 3,5,7 then client 1 pops
        do_reset();
        txn(0, 1, 4'h3, lat, err, sp_seen, pop_seen, pdin);
        txn(0, 1, 4'h5, lat, err, sp_seen, pop_seen, pdin);
        txn(0, 1, 4'h7, lat, err, sp_seen, pop_seen, pdin);
        txn(1, 0, 4'h0, lat, err, sp_seen, pop_seen, pdin);
        chk("pop_lat", lat, 3);
        chk("pop_err", err, 0);
        chk("pop_strobe", pop_seen, 1);
        chk("pop_dout1", bus.Dout1, 4'h7);
        chk("pop_dout0_held", bus.Dout0, 0);
        chk("pop_count", bus.Count, 2);
        repeat (3) @(negedge Clk);
        chk("dout1_holds", bus.Dout1, 4'h7);

        // Both clients push continuously: round-robin 0,1,0,1
        do_reset();
        @(negedge Clk);
        bus.Op0 = 1'b1; bus.Op1 = 1'b1; bus.Din0 = 4'h1; bus.Din1 = 4'h2;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        nack = 0; n0 = 0; n1 = 0; both_gnt = 0;
        for (int i = 0; i < 40 && nack < 4; i++) begin
            @(negedge Clk);
            if (bus.Gnt0 && bus.Gnt1) both_gnt++;
            if (bus.Ack0) begin
                order[nack] = 0; nack++; n0++; bus.Din0 = 4'h3;
                if (n0 == 2) bus.Req0 = 1'b0;
            end
            if (bus.Ack1) begin
                order[nack] = 1; nack++; n1++; bus.Din1 = 4'h4;
                if (n1 == 2) bus.Req1 = 1'b0;
            end
        end
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        chk("rr_nack", nack, 4);
        chk("rr_order", {order[0][3:0], order[1][3:0], order[2][3:0], order[3][3:0]}, 16'h0101);
        chk("rr_both_gnt", both_gnt, 0);
        chk("rr_count", bus.Count, 4);
        chk("rr_stack", {mem[0], mem[1], mem[2], mem[3]}, 16'h1234);

        // Fill to 8, then a ninth push is rejected
        do_reset();
        for (int k = 0; k < 8; k++) txn(k[0], 1, 4'(k), lat, err, sp_seen, pop_seen, pdin);
        chk("fill_count", bus.Count, 8);
        chk("fill_full", bus.Full, 1);
        txn(0, 1, 4'hF, lat, err, sp_seen, pop_seen, pdin);
        chk("ovf_lat", lat, 2);
        chk("ovf_err", err, 1);
        chk("ovf_no_push", sp_seen, 0);
        chk("ovf_count", bus.Count, 8);
        chk("ovf_full", bus.Full, 1);
        @(negedge Clk);
        chk("err_low_no_ack", {bus.Err0, bus.Err1}, 0);

        // Pop from empty is rejected
        do_reset();
        txn(1, 0, 4'h0, lat, err, sp_seen, pop_seen, pdin);
        chk("unf_lat", lat, 2);
        chk("unf_err", err, 1);
        chk("unf_no_pop", pop_seen, 0);
        chk("unf_count", bus.Count, 0);
        chk("unf_empty", bus.Empty, 1);
`ifdef STACK_ARB_ERR_CNT_EN
        @(negedge Clk);
        chk("unf_errcnt", bus.Err_Cnt, 1);
`endif

        // Reset during WAIT aborts the pop
        do_reset();
        txn(0, 1, 4'h9, lat, err, sp_seen, pop_seen, pdin);
        @(negedge Clk);
        bus.Req0 = 1'b1; bus.Op0 = 1'b0;
        @(negedge Clk);
        chk("abort_issue_pop", bus.Stk_Pop, 1);
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        chk("abort_count", bus.Count, 0);
        chk("abort_ack", {bus.Ack0, bus.Ack1, bus.Gnt0, bus.Stk_Pop}, 0);
        bus.Req0 = 1'b0;
        @(negedge Clk);
        RstN = 1'b1;
        nack = 0;
        repeat (3) begin
            @(negedge Clk);
            if (bus.Ack0 || bus.Ack1) nack++;
        end
        chk("abort_no_ack", nack, 0);
        txn(0, 1, 4'hB, lat, err, sp_seen, pop_seen, pdin);
        chk("post_push_err", err, 0);
        chk("post_push_lat", lat, 2);
        chk("post_push_count", bus.Count, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
